cfu_cmd_initiator: RTL

Initiator side of the CPU<->CFU cmd/rsp handshake. It accepts queued CFU requests from a local producer and drives them onto a CFU responder one at a time. It collects each response, or a timeout marker, into an output queue for a consumer. Two uses: hardware offload sequencer in front of the kws accelerator CFU, and reusable bus-functional driver for responder benches.

---
 rtl/cfu_init_pkg.sv | 31 +++
 rtl/cfu_cmd_initiator_fifo.sv | 58 +++++
 rtl/cfu_cmd_initiator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cfu_init_pkg.sv
// Shared types for the CFU command initiator: FSM states, request/response
// records and the stray-counter helper.
package cfu_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [9:0]  function_id;
    logic [31:0] inputs_0;
    logic [31:0] inputs_1;
  } cfu_req_t;

  typedef struct packed {
    logic        ok;
    logic        timeout;
    logic [31:0] data;
  } cfu_res_t;

  localparam logic [7:0] STRAY_MAX = 8'hFF;
  localparam int REQ_W = $bits(cfu_req_t);
  localparam int RES_W = $bits(cfu_res_t);

  function automatic logic [7:0] stray_inc(input logic [7:0] cnt);
    return (cnt == STRAY_MAX) ? cnt : cnt + 8'h01;
  endfunction

endpackage

// File: rtl/cfu_cmd_initiator_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push is ignored when full
// and pop is ignored when empty, full being judged before any same-cycle pop.
module cfu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage write; cleared on reset so an empty head never reads unknowns.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cfu_cmd_initiator.sv
// Initiator side of the CFU cmd/rsp handshake: queues producer requests,
// issues one command at a time and queues each response or timeout marker.
module cfu_cmd_initiator
  import cfu_init_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_ok,
  output logic        res_timeout,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic        rsp_payload_response_ok,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        busy,
  output logic [7:0]  stray_count
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_r;
  cfu_req_t      cmd_r;
  logic          cmd_valid_r;
  logic [TW-1:0] timer_r;
  logic [7:0]    stray_r;

  cfu_req_t      req_wdata_s;
  cfu_req_t      req_head_s;
  logic          req_full_s;
  logic          req_empty_s;
  logic          req_push_s;
  logic          req_pop_s;

  cfu_res_t      res_wdata_s;
  cfu_res_t      res_head_s;
  logic          res_full_s;
  logic          res_empty_s;
  logic          res_push_s;
  logic          res_pop_s;

  logic          rsp_ready_s;
  logic          rsp_hs_s;
  logic          expire_s;

  assign req_wdata_s = '{function_id: req_function_id,
                         inputs_0:    req_inputs_0,
                         inputs_1:    req_inputs_1};
  assign req_push_s  = req_valid && !req_full_s;
  assign res_pop_s   = res_ready && !res_empty_s;

  cfu_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_push_s),
    .push_data (req_wdata_s),
    .pop       (req_pop_s),
    .head      (req_head_s),
    .full      (req_full_s),
    .empty     (req_empty_s)
  );

  cfu_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (res_push_s),
    .push_data (res_wdata_s),
    .pop       (res_pop_s),
    .head      (res_head_s),
    .full      (res_full_s),
    .empty     (res_empty_s)
  );

  // Per-state handshake decode; a response handshake outranks timer expiry.
  always_comb begin
    req_pop_s   = 1'b0;
    rsp_ready_s = 1'b0;
    rsp_hs_s    = 1'b0;
    expire_s    = 1'b0;
    res_push_s  = 1'b0;
    res_wdata_s = '0;
    case (state_r)
      IDLE: begin
        req_pop_s   = !req_empty_s;
        rsp_ready_s = 1'b1;
      end
      ISSUE: begin
        rsp_ready_s = 1'b1;
      end
      WAIT: begin
        rsp_ready_s = !res_full_s;
        rsp_hs_s    = rsp_valid && rsp_ready_s;
        expire_s    = (timer_r == TIMER_LAST);
        if (rsp_hs_s) begin
          res_push_s  = 1'b1;
          res_wdata_s = '{ok:      rsp_payload_response_ok,
                          timeout: 1'b0,
                          data:    rsp_payload_outputs_0};
        end else if (expire_s && !res_full_s) begin
          res_push_s  = 1'b1;
          res_wdata_s = '{ok: 1'b0, timeout: 1'b1, data: 32'h0000_0000};
        end else begin
          res_push_s  = 1'b0;
        end
      end
      default: begin
        rsp_ready_s = 1'b0;
      end
    endcase
  end

  // Command sequencer: issue, wait for response or timeout, count strays.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cmd_valid_r <= 1'b0;
      cmd_r       <= '0;
      timer_r     <= '0;
      stray_r     <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_pop_s) begin
            cmd_r       <= req_head_s;
            cmd_valid_r <= 1'b1;
            state_r     <= ISSUE;
          end
          if (rsp_valid) begin
            stray_r <= stray_inc(stray_r);
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
            timer_r     <= '0;
            state_r     <= WAIT;
          end
          if (rsp_valid) begin
            stray_r <= stray_inc(stray_r);
          end
        end
        WAIT: begin
          // At expiry with a full response queue the timer parks until space frees.
          if (res_push_s) begin
            state_r <= IDLE;
          end else if (!expire_s) begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready               = !req_full_s;
  assign rsp_ready               = rsp_ready_s && !reset;
  assign cmd_valid               = cmd_valid_r;
  assign cmd_payload_function_id = cmd_r.function_id;
  assign cmd_payload_inputs_0    = cmd_r.inputs_0;
  assign cmd_payload_inputs_1    = cmd_r.inputs_1;
  assign res_valid               = !res_empty_s;
  assign res_data                = res_head_s.data;
  assign res_ok                  = res_head_s.ok;
  assign res_timeout             = res_head_s.timeout;
  assign busy                    = (state_r != IDLE) || !req_empty_s;
  assign stray_count             = stray_r;

endmodule
